// File: rtl/div_unit_pkg.sv
// Shared types and constants for the EX-stage HI/LO divide path.
// The optional build macro DIV_ZERO_FAST_EN is consumed in div_unit.sv.
`ifndef DIV_UNIT_PKG_SV
`define DIV_UNIT_PKG_SV

package div_unit_pkg;

  localparam int unsigned DIV_ITER = 32;

  typedef logic [DIV_ITER-1:0]   Word_t;
  typedef logic [2*DIV_ITER-1:0] Doubleword_t;

  typedef enum logic [1:0] {
    DIV_FREE,
    DIV_ON,
    DIV_END
  } Div_state_t;

  typedef enum logic [3:0] {
    OP_NOP,
    OP_MFHI,
    OP_MFLO,
    OP_MTHI,
    OP_MTLO,
    OP_MULT,
    OP_MULTU,
    OP_DIV,
    OP_DIVU
  } Oper_t;

endpackage

// True when the EX operation must be routed through the multi-cycle divider.
`define NEED_DIV(oper) \
  (((oper) == div_unit_pkg::OP_DIV) || ((oper) == div_unit_pkg::OP_DIVU))

`endif

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_unit_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] sub;

  // Compare at WIDTH+1 bits; the difference always fits WIDTH bits when taken,
  // and with a zero divisor the low bits simply keep collecting the dividend.
  always_comb begin
    trial   = {rem_i, bit_i};
    sub     = trial[WIDTH-1:0] - divisor_i;
    q_bit_o = (trial >= {1'b0, divisor_i});
    rem_o   = q_bit_o ? sub : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider with controller for DIV/DIVU.
// result_o = {remainder, quotient}. Define DIV_ZERO_FAST_EN to resolve
// divide-by-zero in a single cycle instead of running all iterations.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               stallreq_o
);

  localparam logic [WIDTH-1:0] One     = WIDTH'(1);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  Div_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Holds the remaining dividend bits; quotient bits shift in from the bottom.
  logic [WIDTH-1:0]   dq_q, dq_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic               op1_neg, op2_neg;
  logic [WIDTH-1:0]   op1_abs, op2_abs;
  logic [WIDTH-1:0]   zero_quot;
  logic               zero_fast;
  logic [WIDTH-1:0]   step_rem;
  logic               step_q;
  logic [WIDTH-1:0]   q_fin, q_out, r_out;

  // Magnitudes of the operands; the most negative value maps onto itself.
  always_comb begin
    op1_neg   = signed_i & opdata1_i[WIDTH-1];
    op2_neg   = signed_i & opdata2_i[WIDTH-1];
    op1_abs   = op1_neg ? (~opdata1_i + One) : opdata1_i;
    op2_abs   = op2_neg ? (~opdata2_i + One) : opdata2_i;
    zero_quot = op1_neg ? One : '1;
  end

`ifdef DIV_ZERO_FAST_EN
  assign zero_fast = (opdata2_i == '0);
`else
  assign zero_fast = 1'b0;
`endif

  div_unit_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (rem_q),
    .divisor_i(divisor_q),
    .bit_i    (dq_q[WIDTH-1]),
    .rem_o    (step_rem),
    .q_bit_o  (step_q)
  );

  // Sign correction applied to the final iteration's outputs.
  always_comb begin
    q_fin = {dq_q[WIDTH-2:0], step_q};
    q_out = q_neg_q ? (~q_fin + One) : q_fin;
    r_out = r_neg_q ? (~step_rem + One) : step_rem;
  end

  // Controller next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dq_d      = dq_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      DIV_FREE: begin
        if (start_i && !annul_i) begin
          if (zero_fast) begin
            state_d  = DIV_END;
            result_d = {opdata1_i, zero_quot};
            ready_d  = 1'b1;
          end else begin
            state_d   = DIV_ON;
            cnt_d     = '0;
            rem_d     = '0;
            dq_d      = op1_abs;
            divisor_d = op2_abs;
            q_neg_d   = op1_neg ^ op2_neg;
            r_neg_d   = op1_neg;
          end
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_FREE;
          cnt_d   = '0;
        end else begin
          rem_d = step_rem;
          dq_d  = q_fin;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d  = DIV_END;
            cnt_d    = '0;
            result_d = {r_out, q_out};
            ready_d  = 1'b1;
          end
        end
      end
      DIV_END: begin
        if (annul_i || !start_i) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: begin
        state_d  = DIV_FREE;
        result_d = '0;
        ready_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      dq_q      <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dq_q      <= dq_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign busy_o     = (state_q == DIV_ON);
  assign stallreq_o = start_i && !ready_q;

endmodule
